// File: rtl/idli_uart_tx_arb_m.sv
// Round-robin arbiter sharing one nibble-wide UART TX between NUM_REQ requesters, with optional byte lock.
// Define IDLI_UART_ARB_LOCK_TIMEOUT_EN to revoke an idle lock after LOCK_TIMEOUT cycles.
module idli_uart_tx_arb_m #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                    i_uart_gck,
  input  logic                    i_uart_rst_n,
  input  logic [NUM_REQ-1:0][3:0] i_arb_req_data,
  input  logic [NUM_REQ-1:0]      i_arb_req_vld,
  input  logic [NUM_REQ-1:0]      i_arb_req_lock,
  output logic [NUM_REQ-1:0]      o_arb_req_acp,
  output logic [NUM_REQ-1:0]      o_arb_gnt,
  output logic [3:0]              o_uart_tx,
  output logic                    o_uart_tx_vld,
  input  logic                    i_uart_tx_acp
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {ARB, COL_LO, COL_HI, SND_LO, SND_HI} state_t;

  state_t             state_q, state_next;
  logic [OWN_W-1:0]   owner_q, owner_next;
  logic [OWN_W-1:0]   last_q, last_next;
  logic [OWN_W-1:0]   rr_pick;
  logic               rr_found;
  logic               lock_q, lock_next;
  logic [7:0]         byte_q;
  logic [NUM_REQ-1:0] owner_onehot;
  logic               owner_vld;
  logic [3:0]         owner_data;
  logic               timeout;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign owner_onehot[gi] = (owner_q == OWN_W'(gi));
  end

  assign owner_vld  = i_arb_req_vld[owner_q];
  assign owner_data = i_arb_req_data[owner_q];

  // Search starts just after the last released owner and wraps.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!rr_found && i_arb_req_vld[(int'(last_q) + k) % NUM_REQ]) begin
        rr_found = 1'b1;
        rr_pick  = OWN_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

`ifdef IDLI_UART_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt_q;
  logic             lock_idle;

  assign lock_idle = (state_q == COL_LO) && lock_q && !owner_vld;
  assign timeout   = lock_idle && (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1));

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      idle_cnt_q <= '0;
    end else if (lock_idle && !timeout) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_q <= '0;
    end
  end
`else
  // LOCK_TIMEOUT only matters in the timeout build.
  logic unused_lock_cfg;
  assign unused_lock_cfg = (LOCK_TIMEOUT > 0);
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      state_q <= ARB;
      owner_q <= '0;
      last_q  <= OWN_W'(NUM_REQ - 1);
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      owner_q <= owner_next;
      last_q  <= last_next;
      lock_q  <= lock_next;
    end
  end

  always_ff @(posedge i_uart_gck) begin
    if (state_q == COL_LO && owner_vld) byte_q[3:0] <= owner_data;
    if (state_q == COL_HI && owner_vld) byte_q[7:4] <= owner_data;
  end

  always_comb begin
    state_next    = state_q;
    owner_next    = owner_q;
    last_next     = last_q;
    lock_next     = lock_q;
    o_arb_req_acp = '0;
    o_arb_gnt     = owner_onehot;
    o_uart_tx     = 4'h0;
    o_uart_tx_vld = 1'b0;
    case (state_q)
      ARB: begin
        o_arb_gnt = '0;
        if (rr_found) begin
          owner_next = rr_pick;
          state_next = COL_LO;
        end
      end
      COL_LO: begin
        o_arb_req_acp = owner_onehot;
        if (owner_vld) begin
          state_next = COL_HI;
        end else if (timeout) begin
          state_next = ARB;
          last_next  = owner_q;
          lock_next  = 1'b0;
        end
      end
      COL_HI: begin
        o_arb_req_acp = owner_onehot;
        if (owner_vld) begin
          lock_next  = i_arb_req_lock[owner_q];
          state_next = SND_LO;
        end
      end
      SND_LO: begin
        o_uart_tx_vld = 1'b1;
        o_uart_tx     = byte_q[3:0];
        if (i_uart_tx_acp) state_next = SND_HI;
      end
      SND_HI: begin
        // The TX takes this nibble unconditionally, so never wait here.
        o_uart_tx_vld = 1'b1;
        o_uart_tx     = byte_q[7:4];
        if (lock_q) begin
          state_next = COL_LO;
        end else begin
          state_next = ARB;
          last_next  = owner_q;
        end
      end
      default: state_next = ARB;
    endcase
  end
endmodule

// File: tb/tb_idli_uart_tx_arb_m.sv
// Bench for idli_uart_tx_arb_m: directed latency/reset checks, then randomized traffic scored against a message-level model.
module tb_idli_uart_tx_arb_m;
  localparam int NR   = 2;
  localparam int MAXB = 12;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NR-1:0][3:0] req_data;
  logic [NR-1:0]      req_vld;
  logic [NR-1:0]      req_lock;
  logic [NR-1:0]      req_acp;
  logic [NR-1:0]      gnt;
  logic [3:0]         tx;
  logic               tx_vld;
  logic               tx_acp;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         owner;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  logic [7:0] sbyte [NR][MAXB];
  bit         slock [NR][MAXB];
  int         nb    [NR];
  int         pos   [NR];
  int         rd    [NR];
  bit         xfer  [NR];

  idli_uart_tx_arb_m #(.NUM_REQ(NR)) dut (
    .i_uart_gck     (clk),
    .i_uart_rst_n   (rst_n),
    .i_arb_req_data (req_data),
    .i_arb_req_vld  (req_vld),
    .i_arb_req_lock (req_lock),
    .o_arb_req_acp  (req_acp),
    .o_arb_gnt      (gnt),
    .o_uart_tx      (tx),
    .o_uart_tx_vld  (tx_vld),
    .i_uart_tx_acp  (tx_acp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Watches the TX side: pairs lo/hi nibbles into bytes and scores them in order.
  task automatic monitor();
    logic [3:0] lo;
    logic [3:0] held;
    bit         hi_pend;
    bit         holding;
    exp_t       e;
    lo = '0; held = '0; hi_pend = 0; holding = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hi_pend = 0;
        holding = 0;
      end else if (hi_pend) begin
        hi_pend = 0;
        holding = 0;
        check("tx_hi_vld", 32'(tx_vld), 32'd1);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("byte", 32'({tx, lo}), 32'(e.data));
          check("byte_owner_gnt", 32'(gnt), 32'd1 << e.owner);
          $display("byte %02h from req%0d", {tx, lo}, e.owner);
        end
      end else if (tx_vld) begin
        if (holding) check("hold_data", 32'(tx), 32'(held));
        if (tx_acp) begin
          lo      = tx;
          hi_pend = 1;
          holding = 0;
        end else begin
          held    = tx;
          holding = 1;
        end
      end else begin
        if (holding) check("hold_vld", 32'(tx_vld), 32'd1);
        holding = 0;
      end
    end
  endtask

  initial begin
    int         cnt;
    int         i;
    int         len;
    int         remaining;
    int         own;
    int         last;
    bit         l;
    bit         done;
    int         busy;
    int         hold;
    bit         did_hold;
    bit         tx_xfer;
    logic [7:0] b;

    fork
      monitor();
    join_none

    rst_n = 1'b0; req_vld = '0; req_data = '0; req_lock = '0; tx_acp = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_acp", 32'(req_acp), 32'd0);
    check("rst_tx", 32'(tx), 32'd0);
    check("rst_tx_vld", 32'(tx_vld), 32'd0);

    // Single byte 0xA5 from req0, TX always ready.
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); tx_acp = 1'b1; req_vld = 2'b01; req_data[0] = 4'h5;
    sb.push_back('{owner: 0, data: 8'hA5});
    #1 check("c0_gnt", 32'(gnt), 32'd0);
    @(negedge clk); #1;
    check("c1_gnt", 32'(gnt), 32'b01);
    check("c1_acp", 32'(req_acp), 32'b01);
    @(negedge clk); req_data[0] = 4'hA; #1;
    check("c2_gnt", 32'(gnt), 32'b01);
    check("c2_acp", 32'(req_acp), 32'b01);
    @(negedge clk); req_vld = 2'b00; #1;
    check("c3_tx_vld", 32'(tx_vld), 32'd1);
    check("c3_tx", 32'(tx), 32'h5);
    check("c3_gnt", 32'(gnt), 32'b01);
    @(negedge clk); #1;
    check("c4_tx", 32'(tx), 32'hA);
    check("c4_gnt", 32'(gnt), 32'b01);
    @(negedge clk); #1;
    check("c5_gnt", 32'(gnt), 32'd0);
    check("c5_tx_vld", 32'(tx_vld), 32'd0);

    // Reset during COL_HI with req1 owning; req0 must win afterwards.
    @(negedge clk); req_vld = 2'b11; req_data[0] = 4'h7; req_data[1] = 4'h3;
    @(negedge clk); #1 check("pre_rst_gnt", 32'(gnt), 32'b10);
    @(negedge clk); req_data[1] = 4'h4; #1 check("pre_rst_acp", 32'(req_acp), 32'b10);
    rst_n = 1'b0; #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_acp", 32'(req_acp), 32'd0);
    check("mid_rst_tx_vld", 32'(tx_vld), 32'd0);
    check("mid_rst_tx", 32'(tx), 32'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; #1 check("post_rst_arb", 32'(gnt), 32'd0);
    @(negedge clk); #1 check("post_rst_winner", 32'(gnt), 32'b01);
    req_vld = '0; rst_n = 1'b0;
    @(negedge clk);

`ifdef IDLI_UART_ARB_LOCK_TIMEOUT_EN
    // Locked req0 goes silent after one byte; req1 is waiting.
    rst_n = 1'b1;
    @(negedge clk); req_vld = 2'b11; req_lock = 2'b01; req_data[0] = 4'h1; req_data[1] = 4'h9;
    sb.push_back('{owner: 0, data: 8'h21});
    sb.push_back('{owner: 1, data: 8'h99});
    @(negedge clk);
    @(negedge clk); req_data[0] = 4'h2;
    @(negedge clk); req_vld = 2'b10;
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (gnt != 2'b01) break;
      cnt++;
    end
    check("timeout_cycles", 32'(cnt), 32'd16);
    check("timeout_arb", 32'(gnt), 32'd0);
    @(negedge clk); #1 check("timeout_next_owner", 32'(gnt), 32'b10);
    repeat (14) @(negedge clk);
    req_vld = '0; req_lock = '0; rst_n = 1'b0;
    @(negedge clk);
`endif

    // Randomized traffic: per-requester streams of 1-3 byte messages, all but the last byte locked.
    for (int r = 0; r < NR; r++) begin
      nb[r] = 6 + $urandom_range(0, 4);
      i = 0;
      if (r == 1) begin
        sbyte[1][0] = 8'h11; slock[1][0] = 1;
        sbyte[1][1] = 8'h22; slock[1][1] = 1;
        sbyte[1][2] = 8'h33; slock[1][2] = 0;
        i = 3;
      end
      while (i < nb[r]) begin
        len = $urandom_range(1, 3);
        if (i + len > nb[r]) len = nb[r] - i;
        for (int j = 0; j < len; j++) begin
          sbyte[r][i] = 8'($urandom);
          slock[r][i] = (j < len - 1);
          i++;
        end
      end
      rd[r]   = 0;
      pos[r]  = 0;
      xfer[r] = 0;
    end

    // Expected order: every requester is waiting from the start, so messages go round-robin from req0.
    remaining = 0;
    for (int r = 0; r < NR; r++) remaining += nb[r];
    last = NR - 1;
    while (remaining > 0) begin
      own = -1;
      for (int k = 1; k <= NR; k++) begin
        if (own < 0 && rd[(last + k) % NR] < nb[(last + k) % NR]) own = (last + k) % NR;
      end
      do begin
        sb.push_back('{owner: own, data: sbyte[own][rd[own]]});
        l = slock[own][rd[own]];
        rd[own]++;
        remaining--;
      end while (l);
      last = own;
    end

    rst_n = 1'b1;
    busy = 0; hold = 0; did_hold = 0; tx_xfer = 0; done = 0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      done = (sb.size() == 0);
      for (int r = 0; r < NR; r++) begin
        if (xfer[r]) pos[r]++;
        if (pos[r] < 2 * nb[r]) begin
          done        = 0;
          b           = sbyte[r][pos[r] / 2];
          req_data[r] = (pos[r] % 2 == 1) ? b[7:4] : b[3:0];
          req_lock[r] = slock[r][pos[r] / 2];
          req_vld[r]  = gnt[r] ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
          req_vld[r]  = 1'b0;
          req_lock[r] = 1'b0;
        end
      end
      if (tx_xfer) busy = 10;
      if (busy > 0) begin
        tx_acp = 1'b0;
        busy--;
      end else if (hold > 0) begin
        tx_acp = 1'b0;
        hold--;
      end else if (!did_hold && tx_vld) begin
        did_hold = 1;
        hold     = 9;
        tx_acp   = 1'b0;
      end else begin
        tx_acp = ($urandom_range(0, 2) != 0);
      end
      for (int r = 0; r < NR; r++) xfer[r] = req_vld[r] && req_acp[r];
      tx_xfer = tx_acp && tx_vld;
    end
    check("drain_complete", 32'(done), 32'd1);

    req_vld = '0;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/idli_uart_tx_arb_m.md
Name: idli_uart_tx_arb_m

Overview:
Round-robin arbiter and sequencer that shares the single UART transmitter between NUM_REQ requesters (core, debug monitor, ...). It collects one byte as two 4b nibbles from the granted requester at that requester's pace, low nibble first. It then presents the byte to the UART TX as two back-to-back nibbles, which the TX requires: it latches its second nibble unconditionally on the cycle after the first. An optional lock keeps ownership across consecutive bytes so multi-byte messages are not interleaved.

Parameters:
NUM_REQ, 2, number of requesters (>=1); requester 0 has the highest priority after reset.
LOCK_TIMEOUT, 16, idle cycles before a held lock is revoked (used only with IDLI_UART_ARB_LOCK_TIMEOUT_EN); >=1.

Ports:
i_uart_gck  in  1  clock.
i_uart_rst_n  in  1  reset, asynchronous, active-low.
i_arb_req_data  in  NUM_REQ x 4 (sqi_data_t array)  nibble from each requester.
i_arb_req_vld  in  NUM_REQ  requester has a nibble valid.
i_arb_req_lock  in  NUM_REQ  sampled with the high nibble; 1 = keep grant for the next byte.
o_arb_req_acp  out  NUM_REQ  nibble accepted this cycle (vld & acp = transfer).
o_arb_gnt  out  NUM_REQ  one-hot current owner; all-zero in ARB.
o_uart_tx  out  4 (sqi_data_t)  nibble to the UART TX.
o_uart_tx_vld  out  1  nibble valid to the UART TX.
i_uart_tx_acp  in  1  UART TX accepting a nibble.

Behaviour:
- State machine with 5 states:
  - ARB: if any i_arb_req_vld is set, owner_q <= round-robin pick and go to COL_LO. No nibble is accepted in ARB.
  - COL_LO: o_arb_req_acp[owner] = 1. On vld[owner], buf[3:0] <= data and go to COL_HI.
  - COL_HI: o_arb_req_acp[owner] = 1. On vld[owner], buf[7:4] <= data, lock_q <= lock[owner], and go to SND_LO.
  - SND_LO: o_uart_tx_vld = 1, o_uart_tx = buf[3:0]. On i_uart_tx_acp go to SND_HI; otherwise hold with data stable.
  - SND_HI: o_uart_tx_vld = 1, o_uart_tx = buf[7:4]. Move on unconditionally: if lock_q, go to COL_LO with the same owner; else go to ARB and set last_q <= owner.
- Round-robin search starts at (last_q+1) mod NUM_REQ and wraps. last_q resets to NUM_REQ-1, so requester 0 wins first. last_q updates only when a grant is released, never during a locked sequence.
- o_arb_req_acp is asserted only for the owner, only in COL_LO/COL_HI, and is a pure function of state and owner (no combinational path from vld).
- o_arb_gnt = onehot(owner) in every state except ARB.
- Latency: vld seen in ARB at cycle 0 -> COL_LO cycle 1 -> COL_HI cycle 2 -> SND_LO cycle 3 -> SND_HI cycle 4 (assuming the TX is idle and the requester keeps vld high). Locked back-to-back bytes skip ARB.
- The TX stays busy for 9 cycles after SND_HI; the arbiter collects the next byte meanwhile and waits in SND_LO until acp.
- Simultaneous vld from several requesters: exactly one is granted. The others see acp = 0 and must hold their data.
- The owner deasserting vld mid-byte stalls in COL_LO/COL_HI indefinitely; no data is lost.
- NUM_REQ = 1: the grant is always 0; behaviour is otherwise identical.
- Reset (at any time, including mid-byte): state = ARB, owner_q = 0, lock_q = 0, last_q = NUM_REQ-1. All outputs are 0: o_arb_req_acp, o_arb_gnt, o_uart_tx, o_uart_tx_vld. buf is not reset. A partially sent byte is abandoned.

Optional Feature:
IDLI_UART_ARB_LOCK_TIMEOUT_EN:
- Defined: a counter runs while in COL_LO with the lock inherited from the previous byte and vld[owner] = 0. When it reaches LOCK_TIMEOUT cycles, go to ARB, set last_q <= owner, and clear lock_q. The counter clears on any vld[owner] or state change.
- Undefined: no counter; a locked owner holds the UART indefinitely.

Test Plan:
- Single byte: req0 sends 0x5 then 0xA, TX acp always 1 -> o_uart_tx = 0x5 at cycle 3, 0xA at cycle 4; o_arb_gnt = 01 during cycles 1-4, then 00.
- Contention: req0 and req1 vld every cycle after reset, lock = 0 -> byte order is req0, req1, req0, req1; each byte's nibbles are adjacent on o_uart_tx.
- Lock: req1 holds lock = 1 for 3 bytes (0x11, 0x22, 0x33) while req0 is also vld -> all three req1 bytes are sent before any req0 byte; ARB is not visited between them.
- Backpressure: TX acp = 0 for 10 cycles in SND_LO -> o_uart_tx_vld stays 1 and o_uart_tx stays stable at buf[3:0]; SND_HI occurs exactly one cycle after acp rises.
- Reset mid-operation: assert i_uart_rst_n = 0 during COL_HI -> all outputs are 0 immediately; after release, req0 wins first even if req1 was the owner before reset.
- Timeout (macro on, LOCK_TIMEOUT = 16): locked owner goes silent -> grant drops after 16 idle cycles and the waiting requester is granted on the next cycle.
